unary_rate_gen: RTL

Binary-to-unary rate encoder for the 8-bit unary-rate systolic array. It accepts one signed two's-complement operand and emits a sign bit plus a deterministic rate-coded bitstream of 2^(WIDTH-1) bits. The number of 1s in the stream equals the operand magnitude exactly. It sits at the array edge and feeds the `sign_i`/`prod_bit` side of the PE accumulators, which count the 1s back into binary.

---
 rtl/unary_pkg.sv | 35 +++
 rtl/unary_rate_gen_if.sv | 25 ++
 rtl/unary_rate_gen_vdc_rng.sv | 42 ++++
 rtl/unary_rate_gen.sv | 95 +++++++++
 4 files changed

// File: rtl/unary_pkg.sv
// Shared definitions for the unary-rate encoder and the accumulator-side length counter.
package unary_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Magnitude width of a signed operand of the given total width.
    function automatic int mag_w_of(input int width);
        return width - 1;
    endfunction

    // Stream length: one bit per representable magnitude step.
    function automatic int len_of(input int width);
        return 1 << mag_w_of(width);
    endfunction

    // Reverse the low `width` bits of `value`; bits above `width` come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] src;
        logic [31:0] rev;
        src = value;
        rev = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                rev = {rev[30:0], src[0]};
                src = src >> 1;
            end
        end
        return rev;
    endfunction

endpackage

// File: rtl/unary_rate_gen_if.sv
// Operand load / bitstream bus of the unary-rate encoder.
interface unary_rate_gen_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in_data;
    logic             en;
    logic             clr;
    logic             in_ready;
    logic             sign_o;
    logic             bit_o;
    logic             valid_o;
    logic             done_o;
    logic             busy;

    modport master (
        output start, in_data, en, clr,
        input  in_ready, sign_o, bit_o, valid_o, done_o, busy
    );

    modport slave (
        input  start, in_data, en, clr,
        output in_ready, sign_o, bit_o, valid_o, done_o, busy
    );
endinterface

// File: rtl/unary_rate_gen_vdc_rng.sv
// Van der Corput source: a counter whose bit-reversed value visits every
// MAG_W-bit number exactly once per wrap, spread evenly over the period.
module vdc_rng
    import unary_pkg::*;
#(
    parameter int MAG_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [MAG_W-1:0] rng_o,
    output logic             wrap_o
);
    logic [MAG_W-1:0] cnt_q;
    logic [MAG_W-1:0] cnt_d;

    // Next count: clear wins, otherwise step on enable.
    always_comb begin
        // NOTE: default assigned first so every path drives cnt_d; a missed branch would infer a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + MAG_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rng_o  = MAG_W'(bitrev(32'(cnt_q), MAG_W));
    assign wrap_o = &cnt_q;

endmodule

// File: rtl/unary_rate_gen.sv
// Signed binary operand -> sign bit plus a 2^(WIDTH-1)-bit rate-coded stream
// whose count of ones equals the operand magnitude.
module unary_rate_gen
    import unary_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    unary_rate_gen_if.slave  bus
);
    localparam int MAG_W = mag_w_of(WIDTH);

    state_e           state_q, state_d;
    logic             sign_q, sign_d;
    logic [MAG_W-1:0] mag_q, mag_d;

    logic             load;
    logic [WIDTH-1:0] abs_in;
    logic [MAG_W-1:0] load_mag;
    logic [MAG_W-1:0] rng;
    logic             wrap;
    logic             in_run;

    assign in_run = (state_q == ST_RUN);

    // Most-negative input has no positive twin; clamp it to the largest magnitude.
    assign abs_in   = bus.in_data[WIDTH-1] ? -bus.in_data : bus.in_data;
    assign load_mag = abs_in[WIDTH-1] ? {MAG_W{1'b1}} : abs_in[MAG_W-1:0];

    // A fresh load restarts the sequence so every operand sees rng = 0,1/2,1/4,...
    vdc_rng #(
        .MAG_W (MAG_W)
    ) u_rng (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (bus.en && in_run),
        .clr    (bus.clr || load),
        .rng_o  (rng),
        .wrap_o (wrap)
    );

    // Next-state and operand-register logic; clr overrides everything.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        load    = 1'b0;
        if (bus.clr) begin
            state_d = ST_IDLE;
            sign_d  = 1'b0;
            mag_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_d = ST_RUN;
                        sign_d  = bus.in_data[WIDTH-1];
                        mag_d   = load_mag;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.en && wrap) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
        end
    end

    assign bus.in_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign bus.busy     = in_run;
    assign bus.done_o   = (state_q == ST_DONE);
    assign bus.valid_o  = in_run && bus.en;
    assign bus.bit_o    = in_run && (mag_q > rng);
    assign bus.sign_o   = sign_q;

endmodule
